// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock parametrised FIFO.
package fifo_pkg;

  // Status flags derived from the registered read/write pointers.
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_status_t;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage for fifo_sync_param: depth x dw entries, one write port and one
// registered read port. Entries are never cleared; only the output register
// has a reset value.
module fifo_regfile #(
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word on a read, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with power-of-2 depth, SIMD-packed words, occupancy
// count, programmable almost-full/almost-empty flags and a read-valid strobe.
// Optional macro FIFO_ERR_EN adds sticky overflow/underflow outputs.
//
// Handshake: a write is taken when wr=1 and o_full=0; a read is taken when
// rd=1 and o_empty=0. A taken read presents its word on out with o_valid=1
// exactly one cycle later; a request that is not taken has no effect other
// than the optional sticky error flags. Reads never bypass writes.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int bw     = 4,
  parameter int simd   = 1,
  parameter int depth  = 8,
  parameter int af_lvl = 6,
  parameter int ae_lvl = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [simd*bw-1:0]          in,
  input  logic                        wr,
  input  logic                        rd,
  output logic [simd*bw-1:0]          out,
  output logic                        o_valid,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_afull,
  output logic                        o_aempty,
  output logic [$clog2(depth):0]      o_count
`ifdef FIFO_ERR_EN
  ,
  output logic                        o_ovf,
  output logic                        o_udf
`endif
);

  localparam int DW = simd * bw;
  localparam int PW = ptr_w(depth);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] AF_LVL  = PW'(af_lvl);
  localparam logic [PW-1:0] AE_LVL  = PW'(ae_lvl);

  // Reject configurations the pointer scheme cannot represent.
  if (depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: depth must be a power of 2 and at least 2");
  end
  if (af_lvl <= 0 || af_lvl > depth) begin : g_bad_af
    $error("fifo_sync_param: af_lvl must satisfy 0 < af_lvl <= depth");
  end
  if (ae_lvl < 0 || ae_lvl >= depth) begin : g_bad_ae
    $error("fifo_sync_param: ae_lvl must satisfy 0 <= ae_lvl < depth");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          valid_q,  valid_d;
  logic [PW-1:0] count;
  logic          wr_acc, rd_acc;
  fifo_status_t  status;

  // Occupancy wraps modulo 2*depth along with the pointers.
  assign count = wr_ptr_q - rd_ptr_q;

  // Status flags from the registered pointers only.
  always_comb begin
    status        = '0;
    status.empty  = (wr_ptr_q == rd_ptr_q);
    status.full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
    status.afull  = (count >= AF_LVL);
    status.aempty = (count <= AE_LVL);
  end

  assign wr_acc = wr & ~status.full;
  assign rd_acc = rd & ~status.empty;

  // Next-state pointers and read-valid strobe.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer and strobe registers; reset discards all contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

  fifo_regfile #(
    .DW    (DW),
    .DEPTH (depth),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc & ~reset),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in),
    .re    (rd_acc & ~reset),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (out)
  );

  assign o_valid  = valid_q;
  assign o_full   = status.full;
  assign o_empty  = status.empty;
  assign o_afull  = status.afull;
  assign o_aempty = status.aempty;
  assign o_count  = count;

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: set on a refused request, cleared only by reset.
  always_comb begin
    ovf_d = ovf_q | (wr & status.full);
    udf_d = udf_q | (rd & status.empty);
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign o_ovf = ovf_q;
  assign o_udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (default parameters, depth 8).
// Build with FIFO_ERR_EN defined to also check the sticky error flags.
module tb_fifo_sync_param;

  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int PW    = 4;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic          rd;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          o_valid;
  logic          o_full;
  logic          o_empty;
  logic          o_afull;
  logic          o_aempty;
  logic [PW-1:0] o_count;
`ifdef FIFO_ERR_EN
  logic          o_ovf;
  logic          o_udf;
  bit            ovf_m = 1'b0;
  bit            udf_m = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Scoreboard: words the DUT must present, in order.
  logic [DW-1:0] exp_q[$];
  // Reference contents of the FIFO.
  logic [DW-1:0] model_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fifo_sync_param #(
    .bw(4), .simd(1), .depth(DEPTH), .af_lvl(AF), .ae_lvl(AE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .wr       (wr),
    .rd       (rd),
    .out      (dout),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_empty  (o_empty),
    .o_afull  (o_afull),
    .o_aempty (o_aempty),
    .o_count  (o_count)
`ifdef FIFO_ERR_EN
    ,
    .o_ovf    (o_ovf),
    .o_udf    (o_udf)
`endif
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every o_valid pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdata_unexpected: got valid with data %0h, expected no output", dout);
      end else begin
        check("rdata", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // One clock of stimulus; updates the reference model and checks status.
  task automatic step(input bit rst, input bit wr_v, input bit rd_v, input logic [DW-1:0] d);
    bit full_m, empty_m, rd_a, wr_a;
    full_m  = (model_q.size() == DEPTH);
    empty_m = (model_q.size() == 0);
    rd_a    = rd_v && !empty_m && !rst;
    wr_a    = wr_v && !full_m && !rst;
    reset = rst;
    wr    = wr_v;
    rd    = rd_v;
    din   = d;
`ifdef FIFO_ERR_EN
    if (rst) begin
      ovf_m = 1'b0;
      udf_m = 1'b0;
    end else begin
      ovf_m = ovf_m | (wr_v && full_m);
      udf_m = udf_m | (rd_v && empty_m);
    end
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
    end else begin
      if (rd_a) exp_q.push_back(model_q.pop_front());
      if (wr_a) model_q.push_back(d);
    end
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    check("valid",  32'(o_valid),  32'(rd_a));
    check("count",  32'(o_count),  32'(model_q.size()));
    check("empty",  32'(o_empty),  32'(model_q.size() == 0));
    check("full",   32'(o_full),   32'(model_q.size() == DEPTH));
    check("afull",  32'(o_afull),  32'(model_q.size() >= AF));
    check("aempty", 32'(o_aempty), 32'(model_q.size() <= AE));
    if (rst) check("out_reset", 32'(dout), 32'(0));
`ifdef FIFO_ERR_EN
    check("ovf", 32'(o_ovf), 32'(ovf_m));
    check("udf", 32'(o_udf), 32'(udf_m));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;

    // Reset state.
    step(1, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    check("reset_count",  32'(o_count),  32'(0));
    check("reset_aempty", 32'(o_aempty), 32'(1));

    // Fill with 1..8.
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 4'(i));
      check("fill_count",  32'(o_count),  32'(i));
      check("fill_afull",  32'(o_afull),  32'(i >= 6));
      check("fill_aempty", 32'(o_aempty), 32'(i <= 2));
    end
    check("fill_full", 32'(o_full), 32'(1));

    // Write while full is dropped.
    step(0, 1, 0, 4'hF);
    check("ovf_count", 32'(o_count), 32'(8));
`ifdef FIFO_ERR_EN
    check("ovf_set", 32'(o_ovf), 32'(1));
`endif

    // Drain: 1..8 back-to-back.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 4'h0);

    // Read while empty: no strobe, out holds last word.
    step(0, 0, 1, 4'h0);
    check("udf_valid", 32'(o_valid), 32'(0));
    check("out_hold",  32'(dout),    32'(8));
`ifdef FIFO_ERR_EN
    check("udf_set", 32'(o_udf), 32'(1));
`endif

    // Simultaneous rd/wr while empty: write only.
    step(0, 1, 1, 4'hA);
    check("empty_rw_count", 32'(o_count), 32'(1));
    step(0, 0, 1, 4'h0);
    check("empty_rw_data", 32'(dout), 32'(4'hA));

    // Steady streaming at count 4 across pointer wrap.
    for (int i = 1; i <= 4; i++) step(0, 1, 0, 4'(i + 4));
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 4'((i * 3 + 1) & 15));
      check("stream_count", 32'(o_count), 32'(4));
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0);

    // Simultaneous rd/wr while full: read only.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 4'(15 - i));
    step(0, 1, 1, 4'hC);
    check("full_rw_count", 32'(o_count), 32'(7));

    // Down to 5 entries, then reset together with rd/wr.
    step(0, 0, 1, 4'h0);
    step(0, 0, 1, 4'h0);
    check("pre_reset_count", 32'(o_count), 32'(5));
    step(1, 1, 1, 4'h3);
    check("midreset_count", 32'(o_count), 32'(0));
    check("midreset_empty", 32'(o_empty), 32'(1));
    check("midreset_valid", 32'(o_valid), 32'(0));

    // Let the monitor consume any outstanding word, then confirm none left.
    step(0, 0, 0, 4'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
